fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined MIPS datapath: owns the PC register and drives the instruction-memory request.
- Supplies pc_4 to the next-PC logic and takes back its nxt_pc / pc_control redirect.
- Captures fetched instructions into the IF/ID pipeline latch.
- Tolerates multi-cycle instruction hits: a redirect that arrives mid-request is held until the outstanding request returns.

Parameters:
PC_INIT, 32'h00000000, PC value loaded on reset; must be word-aligned.

Ports:
CLK  in  1  system clock, rising edge
nRST  in  1  asynchronous active-low reset
ihit  in  1  instruction memory hit; imemload valid this cycle
imemload  in  32  instruction word returned by memory
imemREN  out  1  instruction read enable
imemaddr  out  32  instruction address (= current PC)
pc_control  in  1  redirect taken (from next-PC logic)
nxt_pc  in  32  redirect target (from next-PC logic)
stall  in  1  decode hazard stall: hold PC and IF/ID
halt  in  1  program halt seen downstream
pc_4  out  32  current PC + 4, to next-PC logic
ifid_valid  out  1  IF/ID latch holds a live instruction
ifid_instr  out  32  latched instruction
ifid_pc4  out  32  latched PC + 4 of that instruction

Behaviour:
- Clock is CLK; reset is nRST, asynchronous, active-low. Assertion at any time, including mid-request or mid-DRAIN, immediately sets:
  - pc = PC_INIT, state = FETCH, redirect_tgt = 0
  - ifid_valid = 0, ifid_instr = 0, ifid_pc4 = 0
- Combinational outputs:
  - imemaddr = pc.
  - pc_4 = pc + 4, modulo 2^32; 32'hFFFFFFFC + 4 wraps to 0.
  - imemREN = 1 in FETCH and DRAIN, 0 in HALTED.
- Redirect targets: nxt_pc[1:0] is ignored; the stored PC always has bits [1:0] = 00.
- States: FETCH, DRAIN, HALTED. Within a cycle, priority is halt > pc_control > stall.
- FETCH, halt=1:
  - go to HALTED; ifid_valid <= 0; pc held.
- FETCH, pc_control=1:
  - ifid_valid <= 0 (flush), regardless of stall.
  - With ihit=1: pc <= nxt_pc; stay in FETCH; imemload is discarded.
  - With ihit=0: redirect_tgt <= nxt_pc; go to DRAIN; pc held so the in-flight request still completes.
- FETCH, ihit=1, stall=0:
  - pc <= pc + 4.
  - ifid_valid <= 1, ifid_instr <= imemload, ifid_pc4 <= pc + 4.
- FETCH, ihit=1, stall=1:
  - pc and IF/ID held; the same address is re-requested next cycle.
- FETCH, ihit=0:
  - pc held.
  - stall=0: ifid_valid <= 0 (bubble); ifid_instr and ifid_pc4 unchanged.
  - stall=1: IF/ID held.
- DRAIN, halt=1:
  - go to HALTED; the outstanding request is abandoned.
- DRAIN, pc_control=1:
  - redirect_tgt <= nxt_pc (newest redirect wins).
  - If ihit=1 in the same cycle: pc <= nxt_pc, go to FETCH.
- DRAIN, ihit=1 (no new redirect):
  - pc <= redirect_tgt, go to FETCH; imemload is discarded.
- DRAIN, otherwise: wait.
- DRAIN, IF/ID handling: ifid_valid <= 0 when stall=0; IF/ID held when stall=1.
- HALTED:
  - terminal until reset; imemREN = 0; all inputs ignored; ifid_valid = 0.
- Latency: with continuous ihit and no stall, one instruction enters IF/ID per cycle. The instruction at PC X is visible on ifid_* the cycle after its ihit.

Decomposition:
- cpu_types_pkg (existing): word_t.
- datapath_types_pkg: add fetch_state_t enum {FETCH, DRAIN, HALTED} and ifid_t packed struct {valid, instr, pc4}.
- One natural sub-module, ifid_latch: the IF/ID register with load, flush and hold controls, reused by the later pipeline-register stages. fetch_stage keeps the FSM, PC register and redirect_tgt.

Test Plan:
- Reset with PC_INIT=0, then ihit held high with imemload = 0x20010001, 0x20020002 -> imemaddr 0, 4, 8 on consecutive cycles; ifid_instr = 0x20010001 with ifid_pc4 = 4, then 0x20020002 with ifid_pc4 = 8; ifid_valid stays 1.
- ihit low for 3 cycles at pc=0x10, stall=0 -> imemaddr stays 0x10; ifid_valid = 0 for those cycles; on ihit, ifid_pc4 = 0x14.
- pc=0x20, ihit=0, pc_control=1, nxt_pc=0x100 -> DRAIN; imemaddr stays 0x20 until ihit; then imemaddr = 0x100; the 0x20 instruction never reaches IF/ID (ifid_valid = 0).
- In DRAIN, a second redirect to 0x200 arrives before ihit -> after ihit, pc = 0x200, not 0x100. Also: nxt_pc = 0x103 loads as 0x100.
- stall=1 with ihit=1 at pc=0x40 for 2 cycles -> pc and IF/ID unchanged. Then stall=1 together with pc_control=1 -> ifid_valid = 0 and pc = nxt_pc (flush beats stall).
- halt=1 during FETCH -> next cycle imemREN = 0, ifid_valid = 0, pc frozen. Separately: nRST pulsed low mid-DRAIN -> immediate pc = PC_INIT, state FETCH, redirect discarded.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Basic CPU-wide types shared by every datapath stage.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
endpackage

// File: rtl/datapath_types_pkg.sv
// Pipeline-level types: fetch FSM states and the IF/ID latch contents.
package datapath_types_pkg;
  import cpu_types_pkg::*;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic  valid;
    word_t instr;
    word_t pc4;
  } ifid_t;
endpackage

// File: rtl/ifid_latch.sv
// IF/ID pipeline register: load captures a new instruction, flush only clears
// valid (payload kept), otherwise the contents hold.
module ifid_latch
  import cpu_types_pkg::*;
  import datapath_types_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc4_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc4_o
);

  ifid_t ifid_q, ifid_d;

  always_comb begin
    ifid_d = ifid_q;
    if (flush_i) begin
      ifid_d.valid = 1'b0;
    end else if (load_i) begin
      ifid_d.valid = 1'b1;
      ifid_d.instr = instr_i;
      ifid_d.pc4   = pc4_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ifid_q <= '0;
    else        ifid_q <= ifid_d;
  end

  assign valid_o = ifid_q.valid;
  assign instr_o = ifid_q.instr;
  assign pc4_o   = ifid_q.pc4;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, redirect handling across multi-cycle
// instruction-memory requests, and the IF/ID latch.
//   state  | meaning
//   FETCH  | normal fetch; PC advances on ihit unless stalled
//   DRAIN  | redirect pending; waiting for the in-flight request to return
//   HALTED | terminal until reset; no memory requests
module fetch_stage
  import cpu_types_pkg::*;
  import datapath_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        pc_control,
  input  logic [31:0] nxt_pc,
  input  logic        stall,
  input  logic        halt,
  output logic [31:0] pc_4,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4
);

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        tgt_q, tgt_d;
  word_t        nxt_al;
  logic         load, flush;

  assign nxt_al   = nxt_pc & 32'hFFFF_FFFC;
  assign imemaddr = pc_q;
  assign pc_4     = pc_q + 32'd4;
  assign imemREN  = (state_q != HALTED);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    load    = 1'b0;
    flush   = 1'b0;
    case (state_q)
      FETCH: begin
        if (halt) begin
          state_d = HALTED;
          flush   = 1'b1;
        end else if (pc_control) begin
          flush = 1'b1;
          if (ihit) begin
            pc_d = nxt_al;
          end else begin
            tgt_d   = nxt_al;
            state_d = DRAIN;
          end
        end else if (ihit) begin
          if (!stall) begin
            pc_d = pc_4;
            load = 1'b1;
          end
        end else if (!stall) begin
          flush = 1'b1;
        end
      end
      DRAIN: begin
        if (halt) begin
          state_d = HALTED;
          flush   = 1'b1;
        end else begin
          flush = !stall;
          // The returning word belongs to the abandoned path and is dropped.
          if (pc_control) begin
            tgt_d = nxt_al;
            if (ihit) begin
              pc_d    = nxt_al;
              state_d = FETCH;
            end
          end else if (ihit) begin
            pc_d    = tgt_q;
            state_d = FETCH;
          end
        end
      end
      HALTED:  flush = 1'b1;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= FETCH;
      pc_q    <= PC_INIT;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
    end
  end

  ifid_latch u_ifid (
    .clk     (CLK),
    .rst_n   (nRST),
    .load_i  (load),
    .flush_i (flush),
    .instr_i (imemload),
    .pc4_i   (pc_4),
    .valid_o (ifid_valid),
    .instr_o (ifid_instr),
    .pc4_o   (ifid_pc4)
  );

endmodule
